// File: rtl/dma_read_streamer.sv
// DMA read engine streaming the FFT result buffer out as valid/ready words; DMA_READ_BITREV_EN selects bit-reversed addressing.
// Output appears 2 cycles after the first read; reads are throttled so the 2-entry FIFO plus in-flight word never exceeds 2.

module dma_read_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
endmodule

module dma_read_streamer #(
  parameter int         FFT_N    = 10,
  parameter int         FFT_DW   = 16,
  parameter logic [1:0] MODE_DMA = 2'd2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  dma_start,
  output logic                  dma_busy,
  output logic                  dma_done,
  output logic                  dma_abort,
  output logic                  ract_dma,
  output logic [FFT_N-2:0]      ra_dma,
  input  logic [FFT_DW*2-1:0]   rdr_dma,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [FFT_DW*2-1:0]   dout_data,
  output logic                  dout_last
);
  localparam int AW = FFT_N - 1;
  localparam int DW = FFT_DW * 2;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_cnt;
  logic          in_flight;
  logic          in_flight_last;
  logic          mode_ok;
  logic          pop;
  logic          push;
  logic          fifo_empty;
  logic [1:0]    fifo_count;
  logic [DW:0]   fifo_head;
  logic [2:0]    occupancy;

  assign mode_ok = (mode == MODE_DMA);
  assign pop     = dout_valid && dout_ready;
  assign push    = in_flight && !dma_abort;

  // A slot being popped this cycle is free by the time the new read returns,
  // which is what sustains one word per cycle with dout_ready held high.
  assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

  always_comb begin
    state_nxt = state;
    ract_dma  = 1'b0;
    dma_done  = 1'b0;
    dma_abort = 1'b0;
    case (state)
      IDLE: begin
        if (dma_start && mode_ok) state_nxt = READ;
      end
      READ: begin
        if (!mode_ok) begin
          dma_abort = 1'b1;
          state_nxt = IDLE;
        end else if (occupancy < 3'd2) begin
          ract_dma = 1'b1;
          if (addr_cnt == '1) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!mode_ok) begin
          dma_abort = 1'b1;
          state_nxt = IDLE;
        end else if (fifo_empty && !in_flight) begin
          dma_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_cnt       <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= ract_dma;
      if (ract_dma) begin
        in_flight_last <= &addr_cnt;
        addr_cnt       <= addr_cnt + AW'(1);
      end else if (dma_abort) begin
        addr_cnt <= '0;
      end
    end
  end

  dma_read_fifo #(.W(DW + 1), .DEPTH(2)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (dma_abort),
    .push      (push),
    .push_data ({in_flight_last, rdr_dma}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign dma_busy   = (state != IDLE);
  assign dout_valid = !fifo_empty;
  assign dout_data  = dout_valid ? fifo_head[DW-1:0] : '0;
  assign dout_last  = dout_valid && fifo_head[DW];

`ifdef DMA_READ_BITREV_EN
  for (genvar i = 0; i < AW; i++) begin : g_bitrev
    assign ra_dma[i] = addr_cnt[AW-1-i];
  end
`else
  assign ra_dma = addr_cnt;
`endif
endmodule

// File: tb/tb_dma_read_streamer.sv
// Scoreboard bench for dma_read_streamer at FFT_N=4: expected addresses/words queued at start, checked by a negedge monitor.
module tb_dma_read_streamer;
  localparam int FFT_N  = 4;
  localparam int FFT_DW = 16;
  localparam int AW     = FFT_N - 1;
  localparam int DW     = 2 * FFT_DW;
  localparam int NW     = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd2;
  logic          dma_start = 1'b0;
  logic          dma_busy, dma_done, dma_abort, ract_dma;
  logic [AW-1:0] ra_dma;
  logic [DW-1:0] rdr_dma = '0;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic [DW-1:0] dout_data;
  logic          dout_last;

  always #5 clk = ~clk;

  dma_read_streamer #(.FFT_N(FFT_N), .FFT_DW(FFT_DW), .MODE_DMA(2'd2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .dma_start(dma_start),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_abort(dma_abort),
    .ract_dma(ract_dma), .ra_dma(ra_dma), .rdr_dma(rdr_dma),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_data(dout_data), .dout_last(dout_last)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Address of the j-th word of a transfer in the buffer.
  function automatic logic [AW-1:0] addr_of(input int j);
    logic [AW-1:0] a;
    logic [AW-1:0] r;
    a = AW'(j);
    r = a;
`ifdef DMA_READ_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
`endif
    return r;
  endfunction

  // Reference model state
  logic [DW-1:0] buf_mem [NW];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW:0]   exp_word_q[$];
  bit            active, done_due, after_rst, after_abort, hold_prev;
  logic [DW:0]   prev_word;
  int            acc, outstanding;
  bit            pend_fire;
  logic [AW-1:0] pend_addr;
  int            first_ract_cyc, first_valid_cyc, first_acc_cyc, last_acc_cyc;
  int            ready_mode = 0;
  int            pidx = 0;
  logic [3:0]    ready_pat = 4'b1001;

  // Buffer: data for a read appears one cycle after the request.
  always @(posedge clk) begin
    #1;
    if (pend_fire) rdr_dma = buf_mem[pend_addr];
    else           rdr_dma = $urandom;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: dout_ready = 1'b1;
      1: begin dout_ready = ready_pat[pidx]; pidx = (pidx + 1) % 4; end
      default: dout_ready = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge clk) begin
    bit was_active, exp_abort, exp_done;
    cyc++;
    if (rst) begin
      active = 0; done_due = 0; outstanding = 0; pend_fire = 0;
      exp_addr_q.delete(); exp_word_q.delete();
      after_rst = 1; hold_prev = 0; after_abort = 0;
    end else begin
      if (after_rst)
        chk("reset_outputs", 64'({dma_busy, dma_done, dma_abort, ract_dma, ra_dma,
                                  dout_valid, dout_data, dout_last}), 64'd0);
      after_rst  = 0;
      was_active = active;
      exp_abort  = active && (mode != 2'd2);
      exp_done   = active && done_due && !exp_abort;
      chk("dma_abort", 64'(dma_abort), 64'(exp_abort));
      chk("dma_done", 64'(dma_done), 64'(exp_done));
      chk("dma_busy", 64'(dma_busy), 64'(active));
      if (after_abort) chk("valid_after_abort", 64'(dout_valid), 64'd0);
      if (hold_prev) begin
        chk("stall_valid", 64'(dout_valid), 64'd1);
        chk("stall_word", 64'({dout_last, dout_data}), 64'(prev_word));
      end
      chk("outstanding_le2", 64'(outstanding <= 2), 64'd1);
      if (mode != 2'd2) chk("ract_gated", 64'(ract_dma), 64'd0);
      pend_fire = ract_dma;
      pend_addr = ra_dma;
      if (ract_dma) begin
        if (exp_addr_q.size() == 0) chk("unexpected_ract", 64'd1, 64'd0);
        else chk("ra_dma", 64'(ra_dma), 64'(exp_addr_q.pop_front()));
        if (first_ract_cyc < 0) first_ract_cyc = cyc;
        outstanding++;
      end
      if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dout_valid && dout_ready) begin
        if (exp_word_q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
        else chk("dout_word", 64'({dout_last, dout_data}), 64'(exp_word_q.pop_front()));
        acc++;
        outstanding--;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        if (acc == NW) done_due = 1;
      end
      hold_prev   = dout_valid && !dout_ready && !exp_abort;
      prev_word   = {dout_last, dout_data};
      after_abort = exp_abort;
      if (exp_abort) begin
        active = 0; done_due = 0; outstanding = 0;
        exp_addr_q.delete(); exp_word_q.delete();
      end else if (exp_done) begin
        active = 0; done_due = 0;
      end
      if (dma_start && mode == 2'd2 && !was_active) begin
        active = 1; acc = 0;
        first_ract_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
        for (int j = 0; j < NW; j++) begin
          exp_addr_q.push_back(addr_of(j));
          exp_word_q.push_back({(j == NW - 1), buf_mem[addr_of(j)]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_buf(input bit rnd);
    for (int k = 0; k < NW; k++) buf_mem[k] = rnd ? $urandom : k * 32'h0001_0001;
  endtask

  task automatic start_xfer();
    step();
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input bit noise);
    int n = 0;
    while (active && n < 400) begin
      step();
      dma_start = noise && ($urandom_range(9) == 0);
      n++;
    end
    dma_start = 1'b0;
    chk({name, "_timeout"}, 64'(active), 64'd0);
    chk({name, "_all_words"}, 64'(exp_word_q.size()), 64'd0);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc < target && n < 200) begin step(); n++; end
    chk("wait_acc_timeout", 64'(acc >= target), 64'd1);
  endtask

  initial begin
    fill_buf(0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Full-rate transfer of the linear pattern
    ready_mode = 0;
    start_xfer();
    wait_idle("t1", 0);
    chk("t1_first_valid_latency", 64'(first_valid_cyc - first_ract_cyc), 64'd2);
    chk("t1_back_to_back", 64'(last_acc_cyc - first_acc_cyc), 64'(NW - 1));

    // Stalling consumer 1,0,0,1
    ready_mode = 1;
    pidx = 0;
    start_xfer();
    wait_idle("t2", 0);

    // Abort after 3 words, then restart from address 0
    ready_mode = 0;
    fill_buf(1);
    start_xfer();
    wait_acc(3);
    mode = 2'd1;
    repeat (3) step();
    chk("abort_idle", 64'(dma_busy), 64'd0);
    mode = 2'd2;
    start_xfer();
    wait_idle("t3", 0);

    // Start with mode 0 is ignored; extra start while busy has no effect
    mode = 2'd0;
    start_xfer();
    repeat (3) step();
    chk("start_mode0_ignored", 64'(dma_busy), 64'd0);
    mode = 2'd2;
    start_xfer();
    repeat (3) step();
    dma_start = 1'b1;
    step();
    dma_start = 1'b0;
    wait_idle("t4", 0);

    // Reset mid-transfer, then a full transfer
    ready_mode = 2;
    start_xfer();
    wait_acc(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    start_xfer();
    wait_idle("t5", 0);

    // Random data, random backpressure, stray start pulses
    for (int t = 0; t < 6; t++) begin
      fill_buf(1);
      start_xfer();
      wait_idle("rand", 1);
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
